// File: rtl/cl_crc_framer.sv
// Streaming byte-wide CRC framer: passes payload through a single output register
// and appends a 4-byte FCS after the last payload byte of every frame.
module cl_crc_framer #(
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
    parameter bit          REFLECT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic [15:0] frame_count
);

    // state | meaning
    // PASS  | forwarding payload bytes, accumulating the CRC
    // FCS   | emitting the four FCS bytes, input stalled
    typedef enum logic {PASS, FCS} state_t;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] POLY_R = reflect32(POLY);

    // Full byte update unrolled into one cycle of combinational logic.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        if (REFLECT) begin
            r[7:0] = r[7:0] ^ d;
            for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY_R) : (r >> 1);
        end else begin
            r[31:24] = r[31:24] ^ d;
            for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    state_t      state;
    logic [31:0] crc;
    logic [1:0]  fcs_idx;
    logic [31:0] fcs;
    logic [7:0]  fcs_byte;
    logic        load_ok;

    assign load_ok = !m_valid || m_ready;
    assign s_ready = (state == PASS) && load_ok;
    assign fcs     = crc ^ XOR_OUT;

    always_comb begin
        fcs_byte = 8'h00;
        if (REFLECT) begin
            case (fcs_idx)
                2'd0: fcs_byte = fcs[7:0];
                2'd1: fcs_byte = fcs[15:8];
                2'd2: fcs_byte = fcs[23:16];
                2'd3: fcs_byte = fcs[31:24];
                default: fcs_byte = 8'h00;
            endcase
        end else begin
            case (fcs_idx)
                2'd0: fcs_byte = fcs[31:24];
                2'd1: fcs_byte = fcs[23:16];
                2'd2: fcs_byte = fcs[15:8];
                2'd3: fcs_byte = fcs[7:0];
                default: fcs_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PASS;
            crc         <= INIT;
            fcs_idx     <= 2'd0;
            m_valid     <= 1'b0;
            m_data      <= 8'h00;
            m_last      <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            case (state)
                PASS: begin
                    if (s_valid && s_ready) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        crc     <= crc_next(crc, s_data);
                        if (s_last) begin
                            state   <= FCS;
                            fcs_idx <= 2'd0;
                        end
                    end else if (load_ok) begin
                        m_valid <= 1'b0;
                    end
                end
                FCS: begin
                    if (load_ok) begin
                        m_data  <= fcs_byte;
                        m_valid <= 1'b1;
                        fcs_idx <= fcs_idx + 2'd1;
                        if (fcs_idx == 2'd3) begin
                            m_last      <= 1'b1;
                            state       <= PASS;
                            crc         <= INIT;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule
